// File: rtl/pc_gen.sv
// Fetch-stage instruction-address generator: reset vector, start-up delay,
// stalled-branch latch and misaligned-target reporting, all outputs registered.
module pc_gen #(
  parameter int                 ADDR_W         = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR   = 32'h3000_0000,
  parameter int                 PC_INC         = 4,
  parameter int                 STARTUP_CYCLES = 0,
  parameter int                 ALIGN_BITS     = 2,
  parameter int                 STALL_W        = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   new_pc,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_target_address_i,
  output logic [ADDR_W-1:0]   pc,
  output logic                ce,
  output logic                redirect_pending_o,
  output logic                misalign_o,
  output logic [ADDR_W-1:0]   misalign_addr_o
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam logic [3:0]        WARM_LAST = 4'(STARTUP_CYCLES);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(PC_INC);

  // Low-bit mask of bits that must be zero in any loaded target.
  function automatic logic [ADDR_W-1:0] align_mask();
    logic [ADDR_W-1:0] m;
    m = {ADDR_W{1'b0}};
    for (int i = 0; i < ADDR_W; i++) begin
      if (i < ALIGN_BITS) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (addr & align_mask()) != {ADDR_W{1'b0}};
  endfunction

  state_t             state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic               pend_valid_r, pend_valid_s;
  logic [ADDR_W-1:0]  pend_addr_r, pend_addr_s;
  logic [ADDR_W-1:0]  pc_s;
  logic               ce_s;
  logic               misalign_s;
  logic [ADDR_W-1:0]  misalign_addr_s;
  logic               load_s;
  logic [ADDR_W-1:0]  target_s;
  logic               unused_stall_s;

  // Only the hold bit of the stall vector matters to fetch.
  assign unused_stall_s     = ^stall;
  assign redirect_pending_o = pend_valid_r;

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_s         = state_r;
    cnt_s           = cnt_r;
    pc_s            = pc;
    ce_s            = ce;
    pend_valid_s    = pend_valid_r;
    pend_addr_s     = pend_addr_r;
    misalign_s      = 1'b0;
    misalign_addr_s = misalign_addr_o;
    load_s          = 1'b0;
    target_s        = {ADDR_W{1'b0}};

    case (state_r)
      S_RESET: begin
        pc_s = RESET_VECTOR;
        if (STARTUP_CYCLES == 0) begin
          state_s = S_RUN;
          ce_s    = 1'b1;
        end else begin
          state_s = S_WARMUP;
          cnt_s   = 4'd1;
          ce_s    = 1'b0;
        end
      end
      S_WARMUP: begin
        pc_s = RESET_VECTOR;
        if (cnt_r == WARM_LAST) begin
          state_s = S_RUN;
          ce_s    = 1'b1;
        end else begin
          cnt_s = cnt_r + 4'd1;
          ce_s  = 1'b0;
        end
      end
      S_RUN: begin
        // Strict priority: flush, stalled capture, stall hold, live branch, latched branch, step.
        if (flush) begin
          load_s       = 1'b1;
          target_s     = new_pc;
          pend_valid_s = 1'b0;
        end else if (stall[0]) begin
          if (branch_flag_i) begin
            pend_valid_s = 1'b1;
            pend_addr_s  = branch_target_address_i;
          end else begin
            pend_valid_s = pend_valid_r;
          end
        end else if (branch_flag_i) begin
          load_s       = 1'b1;
          target_s     = branch_target_address_i;
          pend_valid_s = 1'b0;
        end else if (pend_valid_r) begin
          load_s       = 1'b1;
          target_s     = pend_addr_r;
          pend_valid_s = 1'b0;
        end else begin
          pc_s = pc + PC_STEP;
        end
      end
      default: begin
        state_s      = S_RESET;
        pc_s         = RESET_VECTOR;
        ce_s         = 1'b0;
        pend_valid_s = 1'b0;
        cnt_s        = 4'd0;
      end
    endcase

    if (load_s) begin
      pc_s = target_s & ~align_mask();
      if (is_misaligned(target_s)) begin
        misalign_s      = 1'b1;
        misalign_addr_s = target_s;
      end else begin
        misalign_s = 1'b0;
      end
    end else begin
      misalign_s = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r         <= S_RESET;
      cnt_r           <= 4'd0;
      pc              <= RESET_VECTOR;
      ce              <= 1'b0;
      pend_valid_r    <= 1'b0;
      pend_addr_r     <= {ADDR_W{1'b0}};
      misalign_o      <= 1'b0;
      misalign_addr_o <= {ADDR_W{1'b0}};
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      pc              <= pc_s;
      ce              <= ce_s;
      pend_valid_r    <= pend_valid_s;
      pend_addr_r     <= pend_addr_s;
      misalign_o      <= misalign_s;
      misalign_addr_o <= misalign_addr_s;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed start-up/redirect scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_pc_gen;

  localparam int          STARTUP = 3;
  localparam logic [31:0] RV      = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] pc;
  logic        ce;
  logic        redirect_pending_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_pa, m_maddr;
  logic        m_ce, m_pv, m_mis;
  int          m_since;

  pc_gen #(.STARTUP_CYCLES(STARTUP)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .pc                      (pc),
    .ce                      (ce),
    .redirect_pending_o      (redirect_pending_o),
    .misalign_o              (misalign_o),
    .misalign_addr_o         (misalign_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_load(input logic [31:0] t);
    m_pc = {t[31:2], 2'b00};
    if (t[1:0] != 2'b00) begin
      m_mis   = 1'b1;
      m_maddr = t;
    end
  endtask

  task automatic model_edge(input logic r, input logic [5:0] st, input logic fl,
                            input logic [31:0] npc, input logic bf, input logic [31:0] bt);
    if (!r) begin
      m_pc = RV; m_ce = 1'b0; m_pv = 1'b0; m_pa = 32'h0;
      m_mis = 1'b0; m_maddr = 32'h0; m_since = 0;
    end else if (!m_ce) begin
      m_since++;
      m_mis = 1'b0;
      if (m_since >= STARTUP + 1) m_ce = 1'b1;
    end else begin
      m_mis = 1'b0;
      if (fl) begin
        model_load(npc); m_pv = 1'b0;
      end else if (st[0]) begin
        if (bf) begin m_pv = 1'b1; m_pa = bt; end
      end else if (bf) begin
        model_load(bt); m_pv = 1'b0;
      end else if (m_pv) begin
        model_load(m_pa); m_pv = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic r, input logic [5:0] st, input logic fl,
                      input logic [31:0] npc, input logic bf, input logic [31:0] bt);
    rst = r; stall = st; flush = fl; new_pc = npc;
    branch_flag_i = bf; branch_target_address_i = bt;
    @(posedge clk);
    model_edge(r, st, fl, npc, bf, bt);
    #1;
    check("pc", 64'(pc), 64'(m_pc));
    check("ce", 64'(ce), 64'(m_ce));
    check("pending", 64'(redirect_pending_o), 64'(m_pv));
    check("misalign", 64'(misalign_o), 64'(m_mis));
    check("misalign_addr", 64'(misalign_addr_o), 64'(m_maddr));
  endtask

  task automatic idle();
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b0; stall = 6'd0; flush = 1'b0; new_pc = 32'h0;
    branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
    m_since = 0;

    // Reset and start-up delay
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("reset_pc", 64'(pc), 64'(RV));
    check("reset_ce", 64'(ce), 64'd0);
    // Branch during warm-up must be ignored
    step(1'b1, 6'd1, 1'b1, 32'h0000_0100, 1'b1, 32'h3000_0800);
    idle(); idle();
    check("warm_ce", 64'(ce), 64'd0);
    check("warm_pend", 64'(redirect_pending_o), 64'd0);
    idle();
    check("ce_rise", 64'(ce), 64'd1);
    check("ce_rise_pc", 64'(pc), 64'(RV));
    idle();
    check("first_inc", 64'(pc), 64'h3000_0004);

    // Sequential wrap
    step(1'b1, 6'd0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    check("wrap0", 64'(pc), 64'hFFFF_FFF8);
    idle();
    check("wrap1", 64'(pc), 64'hFFFF_FFFC);
    idle();
    check("wrap2", 64'(pc), 64'h0);

    // Branch arriving during a stall
    step(1'b1, 6'd1, 1'b0, 32'h0, 1'b1, 32'h3000_0100);
    check("stall_pend", 64'(redirect_pending_o), 64'd1);
    check("stall_hold", 64'(pc), 64'h0);
    step(1'b1, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    check("pend_load", 64'(pc), 64'h3000_0100);
    check("pend_clear", 64'(redirect_pending_o), 64'd0);
    idle();
    check("pend_next", 64'(pc), 64'h3000_0104);

    // Priority: flush beats stall and latch; live branch beats latch
    step(1'b1, 6'd1, 1'b0, 32'h0, 1'b1, 32'h3000_0200);
    step(1'b1, 6'd1, 1'b1, 32'h0000_0380, 1'b0, 32'h0);
    check("flush_pc", 64'(pc), 64'h380);
    check("flush_pend", 64'(redirect_pending_o), 64'd0);
    step(1'b1, 6'd1, 1'b0, 32'h0, 1'b1, 32'h3000_0200);
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b1, 32'h3000_0300);
    check("newer_branch", 64'(pc), 64'h3000_0300);

    // Misaligned branch target
    step(1'b1, 6'd0, 1'b0, 32'h0, 1'b1, 32'h3000_0102);
    check("mis_pc", 64'(pc), 64'h3000_0100);
    check("mis_pulse", 64'(misalign_o), 64'd1);
    check("mis_addr", 64'(misalign_addr_o), 64'h3000_0102);
    idle();
    check("mis_drop", 64'(misalign_o), 64'd0);
    check("mis_hold", 64'(misalign_addr_o), 64'h3000_0102);

    // Reset in the middle of a pending stalled branch
    step(1'b1, 6'd1, 1'b0, 32'h0, 1'b1, 32'h3000_0400);
    step(1'b0, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("mid_rst_pc", 64'(pc), 64'(RV));
    check("mid_rst_ce", 64'(ce), 64'd0);
    check("mid_rst_pend", 64'(redirect_pending_o), 64'd0);
    idle(); idle(); idle();
    check("restart_ce0", 64'(ce), 64'd0);
    idle();
    check("restart_ce1", 64'(ce), 64'd1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) t[31:8] = 24'hFFFFFF;
      step(($urandom_range(0, 99) != 0),
           6'($urandom),
           ($urandom_range(0, 19) == 0),
           {t[31:4], 4'($urandom)},
           ($urandom_range(0, 3) == 0),
           t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
